match_controller: RTL and testbench

//   Round/match sequencer for the two-player fighter. Sits between the frame

---
 rtl/game_pkg.sv | 38 +++
 rtl/box_overlap.sv | 27 ++
 rtl/match_controller.sv | 216 +++++++++++++++++++++
 tb/tb_match_controller.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the match controller and its box test.
//   - state and winner encodings
//   - bit offsets of the four 10-bit fields inside a packed {x1,x2,y1,y2} box
//   - field widths for coordinates, health and the round timer
package game_pkg;

  localparam int COORD_W  = 10;
  localparam int BOX_W    = 4 * COORD_W;
  localparam int HEALTH_W = 7;
  localparam int TIMER_W  = 7;

  // LSB position of each field within a box word {x1,x2,y1,y2}
  localparam int BOX_X1 = 3 * COORD_W;
  localparam int BOX_X2 = 2 * COORD_W;
  localparam int BOX_Y1 = 1 * COORD_W;
  localparam int BOX_Y2 = 0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INTRO     = 3'd1,
    ST_FIGHT     = 3'd2,
    ST_KO        = 3'd3,
    ST_MATCH_END = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2,
    WIN_DRAW = 2'd3
  } winner_t;

  function automatic logic [COORD_W-1:0] box_field(input logic [BOX_W-1:0] box,
                                                   input int               lsb);
    return box[lsb +: COORD_W];
  endfunction

endpackage

// File: rtl/box_overlap.sv
// box_overlap: combinational axis-aligned box intersection test.
//   a        in  40  first box  {x1,x2,y1,y2}
//   b        in  40  second box {x1,x2,y1,y2}
//   overlap  out 1   boxes intersect; touching edges count as contact
module box_overlap
  import game_pkg::*;
(
  input  logic [BOX_W-1:0] a,
  input  logic [BOX_W-1:0] b,
  output logic             overlap
);

  logic [COORD_W-1:0] ax1, ax2, ay1, ay2;
  logic [COORD_W-1:0] bx1, bx2, by1, by2;

  assign ax1 = box_field(a, BOX_X1);
  assign ax2 = box_field(a, BOX_X2);
  assign ay1 = box_field(a, BOX_Y1);
  assign ay2 = box_field(a, BOX_Y2);
  assign bx1 = box_field(b, BOX_X1);
  assign bx2 = box_field(b, BOX_X2);
  assign by1 = box_field(b, BOX_Y1);
  assign by2 = box_field(b, BOX_Y2);

  assign overlap = (ax1 <= bx2) && (bx1 <= ax2) && (ay1 <= by2) && (by1 <= ay2);

endmodule

// File: rtl/match_controller.sv
// match_controller: round/match sequencer for the two-player fighter.
// Gates player enables, resolves hit contact, tracks health, the round timer
// and rounds won, and reports round and match winners.
//   clk            in   system clock
//   rst            in   asynchronous reset, active-high
//   frame_tick     in   one-cycle strobe per video frame
//   start          in   level, acted on in IDLE and MATCH_END
//   p1_hitbox      in   P1 attack box {x1,x2,y1,y2}
//   p1_hurtbox     in   P1 body box
//   p2_hitbox      in   P2 attack box
//   p2_hurtbox     in   P2 body box
//   p1_hit_active  in   P1 attack in its active frames
//   p2_hit_active  in   P2 attack in its active frames
//   state          out  current state code
//   p1_enable      out  P1 may act (FIGHT only)
//   p2_enable      out  P2 may act (FIGHT only)
//   p1_health      out  P1 remaining health
//   p2_health      out  P2 remaining health
//   timer_sec      out  round seconds remaining
//   p1_rounds      out  rounds won by P1
//   p2_rounds      out  rounds won by P2
//   winner         out  0 none, 1 P1, 2 P2, 3 draw
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for start after reset
// INTRO     | round introduction, counting INTRO_FRAMES ticks
// FIGHT     | players enabled, hits and timer active
// KO        | round over, winner shown for KO_FRAMES ticks
// MATCH_END | match decided, outputs held until start
module match_controller
  import game_pkg::*;
#(
  parameter int HEALTH_MAX     = 100,
  parameter int DAMAGE         = 10,
  parameter int ROUND_SECONDS  = 99,
  parameter int FRAMES_PER_SEC = 60,
  parameter int INTRO_FRAMES   = 120,
  parameter int KO_FRAMES      = 180,
  parameter int ROUNDS_TO_WIN  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic                start,
  input  logic [BOX_W-1:0]    p1_hitbox,
  input  logic [BOX_W-1:0]    p1_hurtbox,
  input  logic [BOX_W-1:0]    p2_hitbox,
  input  logic [BOX_W-1:0]    p2_hurtbox,
  input  logic                p1_hit_active,
  input  logic                p2_hit_active,
  output logic [2:0]          state,
  output logic                p1_enable,
  output logic                p2_enable,
  output logic [HEALTH_W-1:0] p1_health,
  output logic [HEALTH_W-1:0] p2_health,
  output logic [TIMER_W-1:0]  timer_sec,
  output logic [1:0]          p1_rounds,
  output logic [1:0]          p2_rounds,
  output logic [1:0]          winner
);

  localparam int FRAME_CNT_W = $clog2((KO_FRAMES > INTRO_FRAMES) ? KO_FRAMES : INTRO_FRAMES);
  localparam int SEC_CNT_W   = $clog2(FRAMES_PER_SEC);

  localparam logic [HEALTH_W-1:0]    HEALTH_INIT = HEALTH_W'(HEALTH_MAX);
  localparam logic [HEALTH_W-1:0]    DAMAGE_V    = HEALTH_W'(DAMAGE);
  localparam logic [TIMER_W-1:0]     TIMER_INIT  = TIMER_W'(ROUND_SECONDS);
  localparam logic [1:0]             ROUNDS_WIN  = 2'(ROUNDS_TO_WIN);
  localparam logic [FRAME_CNT_W-1:0] INTRO_LOAD  = FRAME_CNT_W'(INTRO_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] KO_LOAD     = FRAME_CNT_W'(KO_FRAMES - 1);
  localparam logic [SEC_CNT_W-1:0]   SEC_LOAD    = SEC_CNT_W'(FRAMES_PER_SEC - 1);

  state_t                 state_q;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic [SEC_CNT_W-1:0]   sec_cnt;
  logic                   hit1_q, hit2_q;

  logic                   p1_on_p2, p2_on_p1;
  logic                   land1, land2;
  logic [HEALTH_W-1:0]    p1_health_nxt, p2_health_nxt;
  logic [TIMER_W-1:0]     timer_nxt;
  logic                   round_over;
  winner_t                round_win;
  logic [1:0]             p1_rounds_inc, p2_rounds_inc;

  box_overlap u_p1_on_p2 (
    .a       (p1_hitbox),
    .b       (p2_hurtbox),
    .overlap (p1_on_p2)
  );

  box_overlap u_p2_on_p1 (
    .a       (p2_hitbox),
    .b       (p1_hurtbox),
    .overlap (p2_on_p1)
  );

  assign state     = state_q;
  assign p1_enable = (state_q == ST_FIGHT);
  assign p2_enable = (state_q == ST_FIGHT);

  // Per-tick FIGHT results; applied by the sequential block only on a tick.
  always_comb begin
    land1 = p1_hit_active && !hit1_q && p1_on_p2;
    land2 = p2_hit_active && !hit2_q && p2_on_p1;

    p2_health_nxt = p2_health;
    if (land1) p2_health_nxt = (p2_health > DAMAGE_V) ? p2_health - DAMAGE_V : '0;
    p1_health_nxt = p1_health;
    if (land2) p1_health_nxt = (p1_health > DAMAGE_V) ? p1_health - DAMAGE_V : '0;

    timer_nxt = timer_sec;
    if (sec_cnt == '0 && timer_sec != '0) timer_nxt = timer_sec - TIMER_W'(1);

    round_over = (p1_health_nxt == '0) || (p2_health_nxt == '0) || (timer_nxt == '0);

    if (p1_health_nxt > p2_health_nxt)      round_win = WIN_P1;
    else if (p1_health_nxt < p2_health_nxt) round_win = WIN_P2;
    else                                    round_win = WIN_DRAW;

    p1_rounds_inc = (p1_rounds == ROUNDS_WIN) ? p1_rounds : p1_rounds + 2'd1;
    p2_rounds_inc = (p2_rounds == ROUNDS_WIN) ? p2_rounds : p2_rounds + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      p1_health <= HEALTH_INIT;
      p2_health <= HEALTH_INIT;
      timer_sec <= TIMER_INIT;
      p1_rounds <= '0;
      p2_rounds <= '0;
      winner    <= WIN_NONE;
      frame_cnt <= '0;
      sec_cnt   <= SEC_LOAD;
      hit1_q    <= 1'b0;
      hit2_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_MATCH_END: begin
          // start is a level and is honoured without waiting for a frame tick
          if (start) begin
            state_q   <= ST_INTRO;
            p1_health <= HEALTH_INIT;
            p2_health <= HEALTH_INIT;
            timer_sec <= TIMER_INIT;
            p1_rounds <= '0;
            p2_rounds <= '0;
            winner    <= WIN_NONE;
            frame_cnt <= INTRO_LOAD;
            hit1_q    <= 1'b0;
            hit2_q    <= 1'b0;
          end
        end

        ST_INTRO: begin
          if (frame_tick) begin
            if (frame_cnt == '0) begin
              state_q <= ST_FIGHT;
              sec_cnt <= SEC_LOAD;
            end else begin
              frame_cnt <= frame_cnt - FRAME_CNT_W'(1);
            end
          end
        end

        ST_FIGHT: begin
          if (frame_tick) begin
            p1_health <= p1_health_nxt;
            p2_health <= p2_health_nxt;
            timer_sec <= timer_nxt;
            sec_cnt   <= (sec_cnt == '0) ? SEC_LOAD : sec_cnt - SEC_CNT_W'(1);
            // latch holds for the rest of the attack so one attack lands once
            hit1_q    <= p1_hit_active && (hit1_q || land1);
            hit2_q    <= p2_hit_active && (hit2_q || land2);
            if (round_over) begin
              state_q   <= ST_KO;
              winner    <= round_win;
              frame_cnt <= KO_LOAD;
              if (round_win == WIN_P1) p1_rounds <= p1_rounds_inc;
              if (round_win == WIN_P2) p2_rounds <= p2_rounds_inc;
            end
          end
        end

        ST_KO: begin
          if (frame_tick) begin
            if (frame_cnt == '0) begin
              if (p1_rounds == ROUNDS_WIN || p2_rounds == ROUNDS_WIN) begin
                state_q <= ST_MATCH_END;
                if (p1_rounds == ROUNDS_WIN && p2_rounds == ROUNDS_WIN) winner <= WIN_DRAW;
                else if (p1_rounds == ROUNDS_WIN)                       winner <= WIN_P1;
                else                                                    winner <= WIN_P2;
              end else begin
                state_q   <= ST_INTRO;
                p1_health <= HEALTH_INIT;
                p2_health <= HEALTH_INIT;
                timer_sec <= TIMER_INIT;
                winner    <= WIN_NONE;
                frame_cnt <= INTRO_LOAD;
                hit1_q    <= 1'b0;
                hit2_q    <= 1'b0;
              end
            end else begin
              frame_cnt <= frame_cnt - FRAME_CNT_W'(1);
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_controller.sv
module tb_match_controller;

  logic        clk, rst, frame_tick, start;
  logic [39:0] p1_hitbox, p1_hurtbox, p2_hitbox, p2_hurtbox;
  logic        p1_hit_active, p2_hit_active;
  logic [2:0]  state;
  logic        p1_enable, p2_enable;
  logic [6:0]  p1_health, p2_health, timer_sec;
  logic [1:0]  p1_rounds, p2_rounds, winner;

  int vectors;
  int miscompares;

  match_controller dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .start         (start),
    .p1_hitbox     (p1_hitbox),
    .p1_hurtbox    (p1_hurtbox),
    .p2_hitbox     (p2_hitbox),
    .p2_hurtbox    (p2_hurtbox),
    .p1_hit_active (p1_hit_active),
    .p2_hit_active (p2_hit_active),
    .state         (state),
    .p1_enable     (p1_enable),
    .p2_enable     (p2_enable),
    .p1_health     (p1_health),
    .p2_health     (p2_health),
    .timer_sec     (timer_sec),
    .p1_rounds     (p1_rounds),
    .p2_rounds     (p2_rounds),
    .winner        (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [39:0] mk_box(input int x1, input int x2, input int y1, input int y2);
    return {x1[9:0], x2[9:0], y1[9:0], y2[9:0]};
  endfunction

  // Inputs change only at the falling edge; outputs are read there too.
  task automatic tick_n(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    start         = 1'b0;
    frame_tick    = 1'b0;
    p1_hit_active = 1'b0;
    p2_hit_active = 1'b0;
    p1_hitbox     = mk_box(0, 10, 0, 10);
    p2_hitbox     = mk_box(0, 10, 0, 10);
    p1_hurtbox    = mk_box(700, 800, 700, 800);
    p2_hurtbox    = mk_box(500, 600, 500, 600);
  endtask

  // P1 attack touching P2 body only along x edge
  task automatic aim_p1();
    p1_hitbox  = mk_box(100, 150, 200, 250);
    p2_hurtbox = mk_box(150, 200, 100, 300);
  endtask

  // P2 attack touching P1 body at the corner
  task automatic aim_p2();
    p2_hitbox  = mk_box(10, 50, 10, 50);
    p1_hurtbox = mk_box(50, 90, 50, 90);
  endtask

  task automatic test_reset();
    clear_inputs();
    do_reset();
    vectors++;
    if ({state, p1_enable, p2_enable} !== {3'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state got state=%0d en=%b%b want state=0 en=00", state, p1_enable, p2_enable);
    end
    vectors++;
    if ({p1_health, p2_health, timer_sec} !== {7'd100, 7'd100, 7'd99}) begin
      miscompares++;
      $display("FAIL reset_counts got h1=%0d h2=%0d t=%0d want 100 100 99", p1_health, p2_health, timer_sec);
    end
    vectors++;
    if ({p1_rounds, p2_rounds, winner} !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_rounds got r1=%0d r2=%0d w=%0d want 0 0 0", p1_rounds, p2_rounds, winner);
    end
    tick_n(3);
    vectors++;
    if (state !== 3'd0) begin
      miscompares++;
      $display("FAIL idle_hold got state=%0d want 0", state);
    end
  endtask

  task automatic test_intro();
    pulse_start();
    vectors++;
    if (state !== 3'd1) begin
      miscompares++;
      $display("FAIL start_to_intro got state=%0d want 1", state);
    end
    tick_n(119);
    vectors++;
    if ({state, p1_enable} !== {3'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL intro_119 got state=%0d en=%b want state=1 en=0", state, p1_enable);
    end
    tick_n(1);
    vectors++;
    if ({state, p1_enable, p2_enable} !== {3'd2, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL intro_to_fight got state=%0d en=%b%b want state=2 en=11", state, p1_enable, p2_enable);
    end
  endtask

  task automatic test_hit_once();
    aim_p1();
    p1_hit_active = 1'b1;
    tick_n(5);
    vectors++;
    if ({p1_health, p2_health} !== {7'd100, 7'd90}) begin
      miscompares++;
      $display("FAIL held_attack got h1=%0d h2=%0d want 100 90", p1_health, p2_health);
    end
    p1_hit_active = 1'b0;
    tick_n(1);
    p1_hit_active = 1'b1;
    tick_n(1);
    vectors++;
    if (p2_health !== 7'd80) begin
      miscompares++;
      $display("FAIL reattack got h2=%0d want 80", p2_health);
    end
    p1_hit_active = 1'b0;
  endtask

  task automatic test_simultaneous();
    clear_inputs();
    do_reset();
    pulse_start();
    tick_n(120);
    aim_p1();
    aim_p2();
    p1_hit_active = 1'b1;
    p2_hit_active = 1'b1;
    tick_n(1);
    vectors++;
    if ({p1_health, p2_health, state} !== {7'd90, 7'd90, 3'd2}) begin
      miscompares++;
      $display("FAIL simultaneous got h1=%0d h2=%0d state=%0d want 90 90 2", p1_health, p2_health, state);
    end
    p1_hit_active = 1'b0;
    p2_hit_active = 1'b0;
    tick_n(1);
    p2_hitbox     = mk_box(10, 49, 10, 49);
    p2_hit_active = 1'b1;
    tick_n(1);
    vectors++;
    if (p1_health !== 7'd90) begin
      miscompares++;
      $display("FAIL one_short_miss got h1=%0d want 90", p1_health);
    end
    p2_hit_active = 1'b0;
  endtask

  task automatic test_ko();
    clear_inputs();
    do_reset();
    pulse_start();
    tick_n(120);
    aim_p1();
    for (int i = 0; i < 10; i++) begin
      p1_hit_active = 1'b1;
      tick_n(1);
      p1_hit_active = 1'b0;
      if (i < 9) tick_n(1);
    end
    vectors++;
    if ({p2_health, p1_health, state} !== {7'd0, 7'd100, 3'd3}) begin
      miscompares++;
      $display("FAIL ko_health got h2=%0d h1=%0d state=%0d want 0 100 3", p2_health, p1_health, state);
    end
    vectors++;
    if ({p1_rounds, p2_rounds, winner, p1_enable, p2_enable} !== {2'd1, 2'd0, 2'd1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL ko_result got r1=%0d r2=%0d w=%0d en=%b%b want 1 0 1 00", p1_rounds, p2_rounds, winner, p1_enable, p2_enable);
    end
    tick_n(179);
    vectors++;
    if (state !== 3'd3) begin
      miscompares++;
      $display("FAIL ko_179 got state=%0d want 3", state);
    end
    tick_n(1);
    vectors++;
    if ({state, p1_health, p2_health, timer_sec, winner, p1_rounds} !== {3'd1, 7'd100, 7'd100, 7'd99, 2'd0, 2'd1}) begin
      miscompares++;
      $display("FAIL next_round got state=%0d h=%0d/%0d t=%0d w=%0d r1=%0d want 1 100/100 99 0 1",
               state, p1_health, p2_health, timer_sec, winner, p1_rounds);
    end
  endtask

  task automatic test_timeout();
    clear_inputs();
    do_reset();
    pulse_start();
    tick_n(120);
    tick_n(59);
    vectors++;
    if (timer_sec !== 7'd99) begin
      miscompares++;
      $display("FAIL timer_59 got t=%0d want 99", timer_sec);
    end
    tick_n(1);
    vectors++;
    if (timer_sec !== 7'd98) begin
      miscompares++;
      $display("FAIL timer_60 got t=%0d want 98", timer_sec);
    end
    tick_n(5879);
    vectors++;
    if ({state, timer_sec} !== {3'd2, 7'd1}) begin
      miscompares++;
      $display("FAIL timer_last got state=%0d t=%0d want 2 1", state, timer_sec);
    end
    tick_n(1);
    vectors++;
    if ({state, timer_sec, winner, p1_rounds, p2_rounds} !== {3'd3, 7'd0, 2'd3, 2'd0, 2'd0}) begin
      miscompares++;
      $display("FAIL timeout_draw got state=%0d t=%0d w=%0d r=%0d/%0d want 3 0 3 0/0",
               state, timer_sec, winner, p1_rounds, p2_rounds);
    end
    tick_n(180);
    tick_n(120);
    aim_p2();
    p2_hit_active = 1'b1;
    tick_n(1);
    p2_hit_active = 1'b0;
    tick_n(5938);
    vectors++;
    if ({state, p1_health} !== {3'd2, 7'd90}) begin
      miscompares++;
      $display("FAIL timeout2_pre got state=%0d h1=%0d want 2 90", state, p1_health);
    end
    tick_n(1);
    vectors++;
    if ({state, winner, p1_rounds, p2_rounds} !== {3'd3, 2'd2, 2'd0, 2'd1}) begin
      miscompares++;
      $display("FAIL timeout_p2 got state=%0d w=%0d r=%0d/%0d want 3 2 0/1", state, winner, p1_rounds, p2_rounds);
    end
  endtask

  task automatic test_match_end();
    clear_inputs();
    do_reset();
    pulse_start();
    aim_p2();
    for (int r = 0; r < 2; r++) begin
      tick_n(120);
      for (int i = 0; i < 10; i++) begin
        p2_hit_active = 1'b1;
        tick_n(1);
        p2_hit_active = 1'b0;
        if (i < 9) tick_n(1);
      end
      tick_n(180);
      if (r == 0) begin
        vectors++;
        if ({state, p2_rounds} !== {3'd1, 2'd1}) begin
          miscompares++;
          $display("FAIL round1_p2 got state=%0d r2=%0d want 1 1", state, p2_rounds);
        end
      end
    end
    vectors++;
    if ({state, winner, p2_rounds, p1_rounds} !== {3'd4, 2'd2, 2'd2, 2'd0}) begin
      miscompares++;
      $display("FAIL match_end got state=%0d w=%0d r=%0d/%0d want 4 2 0/2", state, winner, p1_rounds, p2_rounds);
    end
    tick_n(5);
    vectors++;
    if ({state, winner, p1_enable} !== {3'd4, 2'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL match_hold got state=%0d w=%0d en=%b want 4 2 0", state, winner, p1_enable);
    end
    pulse_start();
    vectors++;
    if ({state, p1_rounds, p2_rounds, winner, p1_health} !== {3'd1, 2'd0, 2'd0, 2'd0, 7'd100}) begin
      miscompares++;
      $display("FAIL restart got state=%0d r=%0d/%0d w=%0d h1=%0d want 1 0/0 0 100",
               state, p1_rounds, p2_rounds, winner, p1_health);
    end
  endtask

  task automatic test_rst_mid();
    tick_n(120);
    aim_p1();
    p1_hit_active = 1'b1;
    tick_n(61);
    p1_hit_active = 1'b0;
    vectors++;
    if ({state, p2_health, timer_sec} !== {3'd2, 7'd90, 7'd98}) begin
      miscompares++;
      $display("FAIL pre_rst got state=%0d h2=%0d t=%0d want 2 90 98", state, p2_health, timer_sec);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({state, p2_health, timer_sec, p1_enable} !== {3'd0, 7'd100, 7'd99, 1'b0}) begin
      miscompares++;
      $display("FAIL async_rst got state=%0d h2=%0d t=%0d en=%b want 0 100 99 0", state, p2_health, timer_sec, p1_enable);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({state, p1_health, p2_health, timer_sec, p1_rounds, p2_rounds, winner} !==
        {3'd0, 7'd100, 7'd100, 7'd99, 2'd0, 2'd0, 2'd0}) begin
      miscompares++;
      $display("FAIL post_rst got state=%0d h=%0d/%0d t=%0d r=%0d/%0d w=%0d", state, p1_health, p2_health,
               timer_sec, p1_rounds, p2_rounds, winner);
    end
  endtask

  // Reference model: phase ticks counted upward, timer derived from total
  // fight ticks, health tracked as plain integers.
  function automatic bit boxes_touch(input logic [39:0] a, input logic [39:0] b);
    int ax1, ax2, ay1, ay2, bx1, bx2, by1, by2;
    ax1 = int'(a[39:30]); ax2 = int'(a[29:20]); ay1 = int'(a[19:10]); ay2 = int'(a[9:0]);
    bx1 = int'(b[39:30]); bx2 = int'(b[29:20]); by1 = int'(b[19:10]); by2 = int'(b[9:0]);
    return (ax1 <= bx2) && (bx1 <= ax2) && (ay1 <= by2) && (by1 <= ay2);
  endfunction

  function automatic logic [39:0] rand_box();
    int x1, y1;
    x1 = int'($urandom_range(0, 40));
    y1 = int'($urandom_range(0, 40));
    return mk_box(x1, x1 + int'($urandom_range(0, 20)), y1, y1 + int'($urandom_range(0, 20)));
  endfunction

  task automatic test_random();
    int m_state, m_h1, m_h2, m_r1, m_r2, m_win, m_cnt, m_fticks, m_timer;
    bit m_l1, m_l2, land1, land2;
    logic [31:0] exp_v, got_v;
    clear_inputs();
    do_reset();
    m_state = 0; m_h1 = 100; m_h2 = 100; m_r1 = 0; m_r2 = 0; m_win = 0;
    m_cnt = 0; m_fticks = 0; m_l1 = 0; m_l2 = 0;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      frame_tick    = ($urandom_range(0, 1) == 1);
      start         = ($urandom_range(0, 15) == 0);
      p1_hit_active = ($urandom_range(0, 2) != 0);
      p2_hit_active = ($urandom_range(0, 2) != 0);
      p1_hitbox     = rand_box();
      p2_hitbox     = rand_box();
      p1_hurtbox    = rand_box();
      p2_hurtbox    = rand_box();
      case (m_state)
        0, 4: if (start) begin
          m_state = 1; m_r1 = 0; m_r2 = 0; m_win = 0; m_h1 = 100; m_h2 = 100;
          m_fticks = 0; m_cnt = 0; m_l1 = 0; m_l2 = 0;
        end
        1: if (frame_tick) begin
          m_cnt++;
          if (m_cnt == 120) begin m_state = 2; m_cnt = 0; end
        end
        2: if (frame_tick) begin
          land1 = p1_hit_active && !m_l1 && boxes_touch(p1_hitbox, p2_hurtbox);
          land2 = p2_hit_active && !m_l2 && boxes_touch(p2_hitbox, p1_hurtbox);
          m_l1 = p1_hit_active && (m_l1 || land1);
          m_l2 = p2_hit_active && (m_l2 || land2);
          if (land1) m_h2 = (m_h2 > 10) ? m_h2 - 10 : 0;
          if (land2) m_h1 = (m_h1 > 10) ? m_h1 - 10 : 0;
          m_fticks++;
          m_timer = 99 - m_fticks / 60;
          if (m_h1 == 0 || m_h2 == 0 || m_timer <= 0) begin
            m_state = 3; m_cnt = 0;
            m_win = (m_h1 > m_h2) ? 1 : (m_h1 < m_h2) ? 2 : 3;
            if (m_win == 1 && m_r1 < 2) m_r1++;
            if (m_win == 2 && m_r2 < 2) m_r2++;
          end
        end
        3: if (frame_tick) begin
          m_cnt++;
          if (m_cnt == 180) begin
            if (m_r1 == 2 || m_r2 == 2) begin
              m_state = 4;
              m_win = (m_r1 == 2 && m_r2 == 2) ? 3 : (m_r1 == 2) ? 1 : 2;
            end else begin
              m_state = 1; m_h1 = 100; m_h2 = 100; m_fticks = 0; m_win = 0;
              m_cnt = 0; m_l1 = 0; m_l2 = 0;
            end
          end
        end
        default: m_state = 0;
      endcase
      @(negedge clk);
      m_timer = 99 - m_fticks / 60;
      if (m_timer < 0) m_timer = 0;
      exp_v = {3'(m_state), (m_state == 2), (m_state == 2), 7'(m_h1), 7'(m_h2), 7'(m_timer),
               2'(m_r1), 2'(m_r2), 2'(m_win)};
      got_v = {state, p1_enable, p2_enable, p1_health, p2_health, timer_sec, p1_rounds, p2_rounds, winner};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL random cyc=%0d got st=%0d h=%0d/%0d t=%0d r=%0d/%0d w=%0d want st=%0d h=%0d/%0d t=%0d r=%0d/%0d w=%0d",
                 cyc, state, p1_health, p2_health, timer_sec, p1_rounds, p2_rounds, winner,
                 m_state, m_h1, m_h2, m_timer, m_r1, m_r2, m_win);
      end
    end
    clear_inputs();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_intro();
    test_hit_once();
    test_simultaneous();
    test_ko();
    test_timeout();
    test_match_end();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
